// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: op codes,
// sequencer state encodings and a counter-width helper.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Bits needed to hold value-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 1;
        while ((64'(1) << bits) < 64'(value)) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Request/response bundle between EX-stage control and the MDU.
// MDU_DIVZERO_FAST_EN adds the div_zero_o flag.
interface mdu_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
`ifdef MDU_DIVZERO_FAST_EN
    logic             div_zero_o;
`endif

    modport master (
        output start_i, op_i, src1_i, src2_i,
`ifdef MDU_DIVZERO_FAST_EN
        input  div_zero_o,
`endif
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i,
`ifdef MDU_DIVZERO_FAST_EN
        output div_zero_o,
`endif
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// acc is the upper half of the working pair; shift_bit is the bit of the
// lower half that enters this step (multiplier LSB or dividend MSB).
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic             shift_bit,
    input  logic [WIDTH-1:0] operand,
    input  logic             div_mode,
    output logic [WIDTH-1:0] acc_next,
    output logic             q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    assign sum   = {1'b0, acc} + (shift_bit ? {1'b0, operand} : '0);
    assign trial = {acc, shift_bit};
    // When the divisor fits, the difference is below 2^WIDTH, so the wrap is harmless.
    assign diff  = trial[WIDTH-1:0] - operand;
    assign fits  = (trial >= {1'b0, operand});

    // Select the multiply or divide result for this iteration.
    always_comb begin
        acc_next = sum[WIDTH:1];
        q_bit    = sum[0];
        if (div_mode) begin
            acc_next = fits ? diff : trial[WIDTH-1:0];
            q_bit    = fits;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Operands are reduced to magnitudes at start, iterated WIDTH times, and
// sign-corrected in FIX. MDU_DIVZERO_FAST_EN lets divide-by-zero skip CALC
// and exposes div_zero_o.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    mdu_ctrl_if.slave  bus
);

    localparam int unsigned     CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef MDU_DIVZERO_FAST_EN
    logic             dzp_q, dzp_d;
`endif

    logic             signed_op, op_is_div, src2_zero;
    logic             src1_neg, src2_neg;
    logic [WIDTH-1:0] mag1, mag2;
    logic             shift_bit, q_bit;
    logic [WIDTH-1:0] step_hi;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign signed_op = ~bus.op_i[0];
    assign op_is_div = bus.op_i[1];
    assign src2_zero = (bus.src2_i == '0);
    assign src1_neg  = signed_op & bus.src1_i[WIDTH-1];
    assign src2_neg  = signed_op & bus.src2_i[WIDTH-1];
    assign mag1      = src1_neg ? -bus.src1_i : bus.src1_i;
    assign mag2      = src2_neg ? -bus.src2_i : bus.src2_i;

    assign shift_bit = div_q ? acc_lo_q[WIDTH-1] : acc_lo_q[0];

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc_hi_q),
        .shift_bit (shift_bit),
        .operand   (opnd_q),
        .div_mode  (div_q),
        .acc_next  (step_hi),
        .q_bit     (q_bit)
    );

    // A zero divisor leaves the dividend magnitude in acc_hi, so only LO needs overriding.
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_res_q ? -prod : prod;
    assign quo_fix  = dz_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
    assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

    // Sequencer next-state, datapath updates and next registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
`ifdef MDU_DIVZERO_FAST_EN
        dzp_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    case (bus.op_i)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            div_d     = op_is_div;
                            neg_res_d = src1_neg ^ src2_neg;
                            neg_rem_d = src1_neg;
                            dz_d      = op_is_div & src2_zero;
                            acc_hi_d  = '0;
                            acc_lo_d  = op_is_div ? mag1 : mag2;
                            opnd_d    = op_is_div ? mag2 : mag1;
                            cnt_d     = CNT_LAST;
                            state_d   = S_CALC;
                            busy_d    = 1'b1;
`ifdef MDU_DIVZERO_FAST_EN
                            if (op_is_div && src2_zero) begin
                                acc_hi_d = mag1;
                                acc_lo_d = '1;
                                state_d  = S_FIX;
                            end
`endif
                        end
                        MDU_MTHI: hi_d = bus.src1_i;
                        MDU_MTLO: lo_d = bus.src1_i;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                acc_hi_d = step_hi;
                acc_lo_d = div_q ? {acc_lo_q[WIDTH-2:0], q_bit}
                                 : {q_bit, acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                busy_d   = 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                if (div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
`ifdef MDU_DIVZERO_FAST_EN
                dzp_d   = dz_q;
`endif
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MDU_DIVZERO_FAST_EN
            dzp_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MDU_DIVZERO_FAST_EN
            dzp_q     <= dzp_d;
`endif
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;
`ifdef MDU_DIVZERO_FAST_EN
    assign bus.div_zero_o = dzp_q;
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO come from native SV
// arithmetic, pushed at issue and popped when done_o appears.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int unsigned W = 32;

`ifdef MDU_DIVZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_ctrl_if #(.WIDTH(W)) bus ();
    mdu_ctrl #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        logic [63:0] p;
        r = '0;
        case (op)
            MDU_MULT: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r.hi = p[63:32]; r.lo = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                r.hi = p[63:32]; r.lo = p[31:0];
            end
            MDU_DIV: begin
                if (b == 0) begin
                    r.lo = '1; r.hi = a; r.dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.lo = a; r.hi = '0;
                end else begin
                    r.lo = $signed(a) / $signed(b);
                    r.hi = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 0) begin
                    r.lo = '1; r.hi = a; r.dz = 1'b1;
                end else begin
                    r.lo = a / b; r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Edges from the accepting edge until done_o is visible.
    function automatic int exp_lat(input exp_t e);
        return (FAST && e.dz) ? 2 : int'(W) + 2;
    endfunction

    function automatic int exp_busy(input exp_t e);
        return (FAST && e.dz) ? 1 : int'(W) + 1;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.op_i = op; bus.src1_i = a; bus.src2_i = b; bus.start_i = 1'b1;
        if (!op[2]) sb.push_back(model(op, a, b));
    endtask

    task automatic wait_done(output int lat, output int busy_cnt, output bit timed_out);
        lat = 0; busy_cnt = 0; timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); @(negedge clk);
            bus.start_i = 1'b0;
            lat++;
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) begin timed_out = 1'b0; break; end
        end
    endtask

    // Runs a table of arithmetic ops and checks latency, busy length and HI/LO.
    task automatic run_table(input string name, input logic [2:0] ops[], input logic [W-1:0] as[], input logic [W-1:0] bs[]);
        int lat, bc; bit to; exp_t e;
        for (int k = 0; k < ops.size(); k++) begin
            issue(ops[k], as[k], bs[k]);
            wait_done(lat, bc, to);
            e = sb.pop_front();
            n_cmp++; if (to) begin n_bad++; $display("FAIL %s[%0d] timeout waiting for done_o", name, k); end
            else begin
                n_cmp++; if (lat !== exp_lat(e)) begin n_bad++; $display("FAIL %s[%0d] latency got %0d want %0d", name, k, lat, exp_lat(e)); end
                n_cmp++; if (bc !== exp_busy(e)) begin n_bad++; $display("FAIL %s[%0d] busy cycles got %0d want %0d", name, k, bc, exp_busy(e)); end
                n_cmp++; if (bus.hi_o !== e.hi) begin n_bad++; $display("FAIL %s[%0d] hi got %h want %h", name, k, bus.hi_o, e.hi); end
                n_cmp++; if (bus.lo_o !== e.lo) begin n_bad++; $display("FAIL %s[%0d] lo got %h want %h", name, k, bus.lo_o, e.lo); end
`ifdef MDU_DIVZERO_FAST_EN
                n_cmp++; if (bus.div_zero_o !== e.dz) begin n_bad++; $display("FAIL %s[%0d] div_zero got %b want %b", name, k, bus.div_zero_o, e.dz); end
`endif
                last_hi = e.hi; last_lo = e.lo;
                @(posedge clk); @(negedge clk);
                n_cmp++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL %s[%0d] after done busy/done got %b%b want 00", name, k, bus.busy_o, bus.done_o); end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if ({bus.busy_o, bus.done_o} !== 2'b00) begin n_bad++; $display("FAIL reset busy/done got %b%b want 00", bus.busy_o, bus.done_o); end
        n_cmp++; if (bus.hi_o !== '0 || bus.lo_o !== '0) begin n_bad++; $display("FAIL reset hi/lo got %h/%h want 0/0", bus.hi_o, bus.lo_o); end
`ifdef MDU_DIVZERO_FAST_EN
        n_cmp++; if (bus.div_zero_o !== 1'b0) begin n_bad++; $display("FAIL reset div_zero got %b want 0", bus.div_zero_o); end
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++; if ({bus.busy_o, bus.done_o} !== 2'b00) begin n_bad++; $display("FAIL post_reset busy/done got %b%b want 00", bus.busy_o, bus.done_o); end
    endtask

    task automatic test_mult();
        logic [2:0] ops[] = '{MDU_MULT, MDU_MULTU, MDU_MULT};
        logic [W-1:0] as[] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [W-1:0] bs[] = '{32'h0000_0007, 32'hFFFF_FFFF, 32'h8000_0000};
        run_table("mult", ops, as, bs);
    endtask

    task automatic test_div();
        logic [2:0] ops[] = '{MDU_DIV, MDU_DIVU, MDU_DIV};
        logic [W-1:0] as[] = '{32'hFFFF_FFF9, 32'd100, 32'd7};
        logic [W-1:0] bs[] = '{32'd2, 32'd7, 32'hFFFF_FFFE};
        run_table("div", ops, as, bs);
    endtask

    task automatic test_div_corner();
        logic [2:0] ops[] = '{MDU_DIV, MDU_DIVU, MDU_DIV};
        logic [W-1:0] as[] = '{32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
        logic [W-1:0] bs[] = '{32'hFFFF_FFFF, 32'd0, 32'd0};
        run_table("divcorner", ops, as, bs);
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = MDU_MTHI; bus.src1_i = 32'h1234_5678; bus.src2_i = '0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (bus.hi_o !== 32'h1234_5678 || bus.lo_o !== last_lo) begin n_bad++; $display("FAIL mthi hi/lo got %h/%h want 12345678/%h", bus.hi_o, bus.lo_o, last_lo); end
        n_cmp++; if ({bus.busy_o, bus.done_o} !== 2'b00) begin n_bad++; $display("FAIL mthi busy/done got %b%b want 00", bus.busy_o, bus.done_o); end
        bus.op_i = MDU_MTLO; bus.src1_i = 32'h9ABC_DEF0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (bus.hi_o !== 32'h1234_5678 || bus.lo_o !== 32'h9ABC_DEF0) begin n_bad++; $display("FAIL mtlo hi/lo got %h/%h want 12345678/9abcdef0", bus.hi_o, bus.lo_o); end
        n_cmp++; if ({bus.busy_o, bus.done_o} !== 2'b00) begin n_bad++; $display("FAIL mtlo busy/done got %b%b want 00", bus.busy_o, bus.done_o); end
        bus.op_i = 3'b110; bus.src1_i = 32'hFFFF_0000;
        @(posedge clk); @(negedge clk);
        bus.op_i = 3'b111;
        @(posedge clk); @(negedge clk);
        bus.start_i = 1'b0;
        n_cmp++; if (bus.hi_o !== 32'h1234_5678 || bus.lo_o !== 32'h9ABC_DEF0 || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reserved hi/lo/busy got %h/%h/%b want 12345678/9abcdef0/0", bus.hi_o, bus.lo_o, bus.busy_o); end
        last_hi = 32'h1234_5678; last_lo = 32'h9ABC_DEF0;
    endtask

    task automatic test_busy_ignore();
        int lat; bit seen; exp_t e;
        issue(MDU_MULT, 32'h0000_1234, 32'hFFFF_FFFE);
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (lat >= 3 && lat <= 7) begin
                bus.start_i = 1'b1; bus.op_i = MDU_MTHI; bus.src1_i = 32'hDEAD_BEEF;
            end else if (lat >= 8 && lat <= 12) begin
                bus.start_i = 1'b1; bus.op_i = MDU_DIV; bus.src1_i = 32'd100; bus.src2_i = 32'd3;
            end else begin
                bus.start_i = 1'b0;
            end
            if (bus.done_o) begin seen = 1'b1; break; end
            n_cmp++; if (bus.hi_o !== last_hi || bus.lo_o !== last_lo) begin n_bad++; $display("FAIL busy_hold cyc %0d hi/lo got %h/%h want %h/%h", lat, bus.hi_o, bus.lo_o, last_hi, last_lo); end
        end
        e = sb.pop_front();
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL busy_ignore timeout waiting for done_o"); end
        else begin
            n_cmp++; if (lat !== exp_lat(e)) begin n_bad++; $display("FAIL busy_ignore latency got %0d want %0d", lat, exp_lat(e)); end
            n_cmp++; if (bus.hi_o !== e.hi || bus.lo_o !== e.lo) begin n_bad++; $display("FAIL busy_ignore hi/lo got %h/%h want %h/%h", bus.hi_o, bus.lo_o, e.hi, e.lo); end
            bus.start_i = 1'b1; bus.op_i = MDU_MTLO; bus.src1_i = 32'h5555_5555;
            @(posedge clk); @(negedge clk);
            bus.start_i = 1'b0;
            n_cmp++; if (bus.lo_o !== e.lo || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL done_ignore lo/busy got %h/%b want %h/0", bus.lo_o, bus.busy_o, e.lo); end
            @(posedge clk); @(negedge clk);
            n_cmp++; if (bus.busy_o !== 1'b0 || bus.hi_o !== e.hi) begin n_bad++; $display("FAIL no_late_start busy/hi got %b/%h want 0/%h", bus.busy_o, bus.hi_o, e.hi); end
            last_hi = e.hi; last_lo = e.lo;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int dones;
        logic [2:0] ops[] = '{MDU_MULTU};
        logic [W-1:0] as[] = '{32'd6};
        logic [W-1:0] bs[] = '{32'd7};
        issue(MDU_DIV, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); @(negedge clk); bus.start_i = 1'b0; end
        e = sb.pop_front();
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL reset_mid busy before reset got %b want 1", bus.busy_o); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.hi_o !== '0 || bus.lo_o !== '0) begin n_bad++; $display("FAIL reset_mid hi/lo got %h/%h want 0/0", bus.hi_o, bus.lo_o); end
        n_cmp++; if ({bus.busy_o, bus.done_o} !== 2'b00) begin n_bad++; $display("FAIL reset_mid busy/done got %b%b want 00", bus.busy_o, bus.done_o); end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin @(posedge clk); @(negedge clk); if (bus.done_o) dones++; end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL reset_mid stray done pulses got %0d want 0", dones); end
        last_hi = '0; last_lo = '0;
        run_table("after_reset", ops, as, bs);
    endtask

    initial begin
        bus.start_i = 1'b0; bus.op_i = '0; bus.src1_i = '0; bus.src2_i = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_mthi_mtlo();
        test_busy_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
